pulse_tick_time_counter: RTL and testbench

- Consumer end of the 100 ms tick link. Takes the pulse train from the clock-domain pulse generator, synchronizes it, and detects rising edges.
- Each detected tick advances a BCD time-of-day counter: tenths, seconds, minutes, hours.
- Flags a stalled or missing tick source through a watchdog.
- Sits between the pulse generator and the 7-segment display/driver logic.

---
 rtl/pulse_tick_time_counter_pkg.sv | 20 ++
 rtl/pulse_tick_time_counter_bcd_mod_counter.sv | 37 +++
 rtl/pulse_tick_time_counter.sv | 135 +++++++++++++
 tb/tb_pulse_tick_time_counter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_tick_time_counter_pkg.sv
// Shared BCD limits, the default watchdog span and a BCD byte validator
// for the tick-driven time-of-day counter.
package pulse_tick_time_counter_pkg;

  typedef logic [7:0] bcd8;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] TENS60_MAX = 4'd5;
  localparam bcd8        SEC_MAX    = {TENS60_MAX, DIGIT_MAX};
  localparam bcd8        MIN_MAX    = {TENS60_MAX, DIGIT_MAX};
  localparam bcd8        HOUR_MAX   = 8'h23;

  localparam int unsigned WDOG_CYCLES_DEFAULT = 60_000_000;

  // Both nibbles must be decimal digits and the byte must not exceed max.
  function automatic logic bcd_valid(input bcd8 v, input bcd8 max);
    return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= DIGIT_MAX) && (v <= max);
  endfunction

endpackage

// File: rtl/pulse_tick_time_counter_bcd_mod_counter.sv
// Two-digit BCD modulo counter (00..MAX) with clear, load and a carry out
// asserted combinationally when an increment wraps MAX back to 00.
module pulse_tick_time_counter_bcd_mod_counter
  import pulse_tick_time_counter_pkg::*;
#(
  parameter bcd8 MAX = SEC_MAX
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic load,
  input  bcd8  load_val,
  input  logic inc,
  output bcd8  value,
  output logic carry_out
);

  assign carry_out = inc && (value == MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value == MAX)
        value <= '0;
      else if (value[3:0] == DIGIT_MAX)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/pulse_tick_time_counter.sv
// Synchronizes the 100 ms tick pulse, advances a BCD time-of-day counter and
// runs a stall watchdog. Define TIME_COUNTER_HOUR12_EN for 12-hour display.
module pulse_tick_time_counter
  import pulse_tick_time_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_pulse,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_load_hour,
  input  logic [7:0] i_load_min,
  input  logic [7:0] i_load_sec,
  output logic [3:0] o_tenths,
  output logic [7:0] o_sec_bcd,
  output logic [7:0] o_min_bcd,
  output logic [7:0] o_hour_bcd,
  output logic       o_pm,
  output logic       o_sec_tick,
  output logic       o_min_tick,
  output logic       o_load_err,
  output logic       o_stalled
);

  localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   edge_p1;
  logic                   tick_p2;
  logic                   tick_det;

  logic [3:0]  tenths_q;
  bcd8         sec_q, min_q, hour_q;
  logic        sec_tick_q, min_tick_q, load_err_q;
  logic [31:0] wdog_cnt;

  logic load_ok, apply, tenths_wrap, sec_carry, min_carry;
  logic day_wrap_unused;

  // Stage p0/p1: synchronizer chain and edge-detect flop
  assign tick_det = sync_p0[SYNC_STAGES-1] & ~edge_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_p0 <= '0;
      edge_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_pulse};
      edge_p1 <= sync_p0[SYNC_STAGES-1];
      tick_p2 <= tick_det;
    end
  end

  // Stage p2: apply tick, clear or load to the time digits
  assign load_ok = i_load && !i_clear
                   && bcd_valid(i_load_hour, HOUR_MAX)
                   && bcd_valid(i_load_min, MIN_MAX)
                   && bcd_valid(i_load_sec, SEC_MAX);
  assign apply       = tick_p2 && i_en && !i_clear && !i_load;
  assign tenths_wrap = apply && (tenths_q == DIGIT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tenths_q   <= '0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      if (i_clear || load_ok)
        tenths_q <= '0;
      else if (apply)
        tenths_q <= tenths_wrap ? 4'd0 : tenths_q + 4'd1;
      sec_tick_q <= tenths_wrap;
      min_tick_q <= sec_carry;
      load_err_q <= i_load && !i_clear && !load_ok;
    end
  end

  pulse_tick_time_counter_bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clear(i_clear), .load(load_ok),
    .load_val(i_load_sec), .inc(tenths_wrap), .value(sec_q), .carry_out(sec_carry)
  );

  pulse_tick_time_counter_bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clear(i_clear), .load(load_ok),
    .load_val(i_load_min), .inc(sec_carry), .value(min_q), .carry_out(min_carry)
  );

  // The day wraps 23 -> 00 silently; nothing consumes the hour carry.
  pulse_tick_time_counter_bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clear(i_clear), .load(load_ok),
    .load_val(i_load_hour), .inc(min_carry), .value(hour_q), .carry_out(day_wrap_unused)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wdog_cnt <= '0;
    else if (!i_en || tick_p2)
      wdog_cnt <= '0;
    else if (wdog_cnt != WDOG_LIMIT)
      wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign o_stalled  = i_en && (wdog_cnt == WDOG_LIMIT);
  assign o_tenths   = tenths_q;
  assign o_sec_bcd  = sec_q;
  assign o_min_bcd  = min_q;
  assign o_sec_tick = sec_tick_q;
  assign o_min_tick = min_tick_q;
  assign o_load_err = load_err_q;

`ifdef TIME_COUNTER_HOUR12_EN
  function automatic bcd8 to_hour12(input bcd8 h24);
    logic [4:0] b;
    b = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
    if (b == 5'd0)
      b = 5'd12;
    else if (b > 5'd12)
      b = b - 5'd12;
    return (b >= 5'd10) ? {4'd1, 4'(b - 5'd10)} : {4'd0, b[3:0]};
  endfunction

  assign o_hour_bcd = to_hour12(hour_q);
  assign o_pm       = (hour_q >= 8'h12);
`else
  assign o_hour_bcd = hour_q;
  assign o_pm       = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_tick_time_counter.sv
// Self-checking bench: time is modelled as tenths since midnight and each
// detected pulse rise schedules one tick SYNC_STAGES+1 edges later.
module tb_pulse_tick_time_counter;

  localparam int SS = 2;
  localparam int WD = 100;
  localparam int DAY = 864000;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_en = 1'b1, i_pulse = 1'b0, i_clear = 1'b0, i_load = 1'b0;
  logic [7:0] i_load_hour = '0, i_load_min = '0, i_load_sec = '0;
  logic [3:0] o_tenths;
  logic [7:0] o_sec_bcd, o_min_bcd, o_hour_bcd;
  logic       o_pm, o_sec_tick, o_min_tick, o_load_err, o_stalled;

  int compared = 0, mismatched = 0;

  int  t, wcnt, edge_no;
  bit  prev;
  int  q[$];
  bit  e_sec, e_min, e_lerr;
  int  sec_strobes, min_strobes, sec_edge, min_edge;

  always #5 i_clk = ~i_clk;

  pulse_tick_time_counter #(.SYNC_STAGES(SS), .WDOG_CYCLES(WD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_pulse(i_pulse),
    .i_clear(i_clear), .i_load(i_load), .i_load_hour(i_load_hour),
    .i_load_min(i_load_min), .i_load_sec(i_load_sec), .o_tenths(o_tenths),
    .o_sec_bcd(o_sec_bcd), .o_min_bcd(o_min_bcd), .o_hour_bcd(o_hour_bcd),
    .o_pm(o_pm), .o_sec_tick(o_sec_tick), .o_min_tick(o_min_tick),
    .o_load_err(o_load_err), .o_stalled(o_stalled)
  );

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  function automatic int bin(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit load_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    if (h[3:0] > 9 || m[3:0] > 9 || s[3:0] > 9) return 1'b0;
    if (m[7:4] > 5 || s[7:4] > 5) return 1'b0;
    if (bin(h) > 23) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; wcnt = 0; prev = 1'b0; q.delete();
    e_sec = 1'b0; e_min = 1'b0; e_lerr = 1'b0;
  endtask

  task automatic model_edge();
    bit tick;
    edge_no++;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    tick = (q.size() > 0 && q[0] == edge_no);
    if (tick) void'(q.pop_front());
    if (i_pulse && !prev) q.push_back(edge_no + SS + 1);
    prev = i_pulse;
    e_sec = 1'b0; e_min = 1'b0; e_lerr = 1'b0;
    if (i_clear)
      t = 0;
    else if (i_load) begin
      if (load_valid(i_load_hour, i_load_min, i_load_sec))
        t = ((bin(i_load_hour) * 60 + bin(i_load_min)) * 60 + bin(i_load_sec)) * 10;
      else
        e_lerr = 1'b1;
    end else if (tick && i_en) begin
      e_sec = (t % 10 == 9);
      e_min = (t % 600 == 599);
      t = (t + 1) % DAY;
    end
    if (!i_en || tick) wcnt = 0;
    else if (wcnt < WD) wcnt++;
  endtask

  task automatic check_outputs(input string tag);
    int h, eh;
    bit epm;
    h = t / 36000;
    eh = h;
    epm = 1'b0;
`ifdef TIME_COUNTER_HOUR12_EN
    eh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    epm = (h >= 12);
`endif
    chk({tag, ".tenths"}, 32'(o_tenths), 32'(t % 10));
    chk({tag, ".sec"}, 32'(o_sec_bcd), 32'(bcd((t / 10) % 60)));
    chk({tag, ".min"}, 32'(o_min_bcd), 32'(bcd((t / 600) % 60)));
    chk({tag, ".hour"}, 32'(o_hour_bcd), 32'(bcd(eh)));
    chk({tag, ".pm"}, 32'(o_pm), 32'(epm));
    chk({tag, ".sec_tick"}, 32'(o_sec_tick), 32'(e_sec));
    chk({tag, ".min_tick"}, 32'(o_min_tick), 32'(e_min));
    chk({tag, ".load_err"}, 32'(o_load_err), 32'(e_lerr));
    chk({tag, ".stalled"}, 32'(o_stalled), 32'(i_en && wcnt == WD));
  endtask

  task automatic cyc(input string tag);
    @(posedge i_clk);
    model_edge();
    #1;
    if (o_sec_tick === 1'b1) begin sec_strobes++; sec_edge = edge_no; end
    if (o_min_tick === 1'b1) begin min_strobes++; min_edge = edge_no; end
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input string tag);
    i_load = 1'b1; i_load_hour = h; i_load_min = m; i_load_sec = s;
    cyc(tag);
    i_load = 1'b0;
  endtask

  task automatic pulses(input int n, input int hi, input int lo, input string tag);
    for (int k = 0; k < n; k++) begin
      i_pulse = 1'b1;
      for (int c = 0; c < hi; c++) cyc(tag);
      i_pulse = 1'b0;
      for (int c = 0; c < lo; c++) cyc(tag);
    end
  endtask

  initial begin
    int changes, rise_edge, change_edge, t_before;
    logic [3:0] last_tenths;
    bit found;
    edge_no = 0;
    model_reset();

    #2;
    async_reset("reset");
    cyc("reset_hold"); cyc("reset_hold");
    i_rst_n = 1'b1;

    // Ten ticks advance one second
    sec_strobes = 0;
    pulses(10, 20, 30, "ten_ticks");
    chk("ten_ticks.sec_final", 32'(o_sec_bcd), 32'h01);
    chk("ten_ticks.tenths_final", 32'(o_tenths), 32'h0);
    chk("ten_ticks.sec_strobes", 32'(sec_strobes), 32'd1);

    // Midnight rollover from 23:59:59.0
    do_load(8'h23, 8'h59, 8'h59, "load_2359");
    sec_strobes = 0; min_strobes = 0; sec_edge = -1; min_edge = -2;
    pulses(10, 5, 10, "rollover");
    chk("rollover.sec_strobes", 32'(sec_strobes), 32'd1);
    chk("rollover.min_strobes", 32'(min_strobes), 32'd1);
    chk("rollover.strobe_align", 32'(min_edge), 32'(sec_edge));
    chk("rollover.min_zero", 32'(o_min_bcd), 32'h00);
`ifdef TIME_COUNTER_HOUR12_EN
    chk("rollover.hour12", 32'(o_hour_bcd), 32'h12);
`else
    chk("rollover.hour24", 32'(o_hour_bcd), 32'h00);
`endif

    // Rejected load, then a load colliding with a tick
    do_load(8'h12, 8'h6A, 8'h00, "bad_load");
    chk("bad_load.err", 32'(o_load_err), 32'd1);
    cyc("bad_load_after");
    chk("bad_load.err_one_cycle", 32'(o_load_err), 32'd0);
    i_pulse = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc("collide_wait");
      found = (q.size() > 0 && q[0] == edge_no + 1);
    end
    chk("collide.aligned", 32'(found), 32'd1);
    do_load(8'h01, 8'h02, 8'h03, "collide_load");
    chk("collide.tenths", 32'(o_tenths), 32'h0);
    chk("collide.sec", 32'(o_sec_bcd), 32'h03);
    i_pulse = 1'b0;
    for (int c = 0; c < 6; c++) cyc("collide_after");
    chk("collide.tick_lost", 32'(o_tenths), 32'h0);

    // Long pulse gives exactly one increment with fixed latency
    i_pulse = 1'b1;
    changes = 0; change_edge = -1;
    last_tenths = o_tenths;
    cyc("long_pulse");
    rise_edge = edge_no;
    for (int c = 1; c < 200; c++) begin
      if (o_tenths !== last_tenths) begin changes++; change_edge = edge_no; end
      last_tenths = o_tenths;
      cyc("long_pulse");
    end
    if (o_tenths !== last_tenths) begin changes++; change_edge = edge_no; end
    i_pulse = 1'b0;
    chk("long_pulse.increments", 32'(changes), 32'd1);
    chk("long_pulse.latency", 32'(change_edge - rise_edge), 32'(SS + 1));
    for (int c = 0; c < 5; c++) cyc("long_pulse_tail");

    // Watchdog
    async_reset("wdog_reset");
    cyc("wdog_reset_hold");
    i_rst_n = 1'b1;
    for (int c = 0; c < WD - 1; c++) cyc("wdog_count");
    chk("wdog.not_yet", 32'(o_stalled), 32'd0);
    cyc("wdog_expire");
    chk("wdog.stalled", 32'(o_stalled), 32'd1);
    for (int c = 0; c < 5; c++) cyc("wdog_saturate");
    i_pulse = 1'b1;
    for (int c = 0; c < 5; c++) cyc("wdog_tick");
    i_pulse = 1'b0;
    chk("wdog.cleared_by_tick", 32'(o_stalled), 32'd0);
    for (int c = 0; c < WD + 5; c++) cyc("wdog_again");
    i_en = 1'b0;
    #1;
    chk("wdog.en_low", 32'(o_stalled), 32'd0);
    cyc("wdog_en_low");

    // Disabled ticks with pulse high; re-enable must not count
    t_before = t;
    i_pulse = 1'b1;
    for (int c = 0; c < 10; c++) cyc("en_low_pulse");
    i_en = 1'b1;
    for (int c = 0; c < 10; c++) cyc("reenable_high");
    i_pulse = 1'b0;
    cyc("reenable_low");
    chk("reenable.no_tick", 32'(o_tenths), 32'(t_before % 10));

    // Reset mid-pulse and mid-count
    do_load(8'h10, 8'h20, 8'h30, "pre_reset_load");
    pulses(3, 4, 4, "pre_reset_ticks");
    i_pulse = 1'b1;
    cyc("mid_pulse"); cyc("mid_pulse");
    async_reset("mid_reset");
    chk("mid_reset.hour", 32'(o_hour_bcd), 32'h00);
    cyc("mid_reset_hold"); cyc("mid_reset_hold");
    i_rst_n = 1'b1;
    for (int c = 0; c < 10; c++) cyc("release_high");
    chk("release_high.one_tick", 32'(o_tenths), 32'h1);
    i_pulse = 1'b0;
    cyc("release_low");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) i_pulse = ~i_pulse;
      if ($urandom_range(0, 31) == 0) i_en = ~i_en;
      i_clear = ($urandom_range(0, 199) == 0);
      i_load = ($urandom_range(0, 99) == 0);
      if (i_load) begin
        i_load_hour = bcd($urandom_range(0, 23));
        i_load_min = bcd($urandom_range(55, 59));
        i_load_sec = bcd($urandom_range(0, 59));
        case ($urandom_range(0, 5))
          0: i_load_hour = 8'($urandom_range(0, 255));
          1: i_load_min = 8'($urandom_range(0, 255));
          2: i_load_sec = 8'($urandom_range(0, 255));
          default: ;
        endcase
      end
      cyc("random");
    end
    i_clear = 1'b0; i_load = 1'b0;
    cyc("random_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
